data_mem_lsu: RTL and testbench
===============================

Name: data_mem_lsu

Overview:
- Load/store unit: the initiator side of the data memory port.
- Accepts single or burst transfer requests from the core sequencer.
- Drives the memory's address, write-enable and write-data inputs, and samples its combinational read-data output.
- Streams read data out, and write data in, over valid/ready handshakes.
- Sits between the control/accumulator datapath and the data memory.

Parameters:
DataWidth, 8, width of data words and of the memory address
LenWidth, 8, width of the burst-length field

Ports:
clk  input  1  system clock; all state updates on rising edge
nReset  input  1  synchronous, active-low reset, sampled on rising clk edge
req_valid  input  1  transfer request present
req_ready  output  1  LSU can accept a request
req_store  input  1  1 = store burst, 0 = load burst
req_addr  input  DataWidth  burst base address
req_len  input  LenWidth  number of words; 0 = no access
rd_data  output  DataWidth  load data word
rd_valid  output  1  rd_data valid
rd_ready  input  1  consumer accepts rd_data
wr_data  input  DataWidth  store data word
wr_valid  input  1  wr_data valid
wr_ready  output  1  LSU accepts wr_data
done  output  1  one-cycle pulse: burst finished
busy  output  1  state != IDLE
mem_addr  output  DataWidth  to memory Addr
mem_we  output  1  to memory WriteEnable
mem_wdata  output  DataWidth  to memory write-data (Accu) input
mem_rdata  input  DataWidth  from memory DataOut; combinational, forced 0 while mem_we=1

Behaviour:
- Reset: one clock, clk. Reset is synchronous and active-low on nReset.
- Reset values: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, rd_data=0, rd_valid=0, wr_ready=0, done=0, busy=0.
- req_ready=1 in IDLE only, including the first cycle after reset.
- States: IDLE, RD, RD_OUT, WR_WAIT, WR, DONE. All outputs are registered except req_ready and busy, which decode state.
- IDLE:
  - On req_valid & req_ready, latch addr_q=req_addr, cnt_q=req_len, op_q=req_store.
  - len=0 -> DONE.
  - Load -> RD.
  - Store -> WR_WAIT.
- RD:
  - mem_addr=addr_q, mem_we=0.
  - At the edge: rd_data<=mem_rdata, rd_valid<=1, go to RD_OUT.
  - mem_rdata is never sampled while mem_we=1.
- RD_OUT:
  - Hold rd_data/rd_valid until rd_ready.
  - On handshake: rd_valid<=0, addr_q<=addr_q+1, cnt_q<=cnt_q-1.
  - Then cnt_q==1 -> DONE, else RD.
- WR_WAIT:
  - wr_ready=1.
  - On wr_valid & wr_ready: mem_wdata<=wr_data, mem_addr<=addr_q, wr_ready<=0, go to WR.
- WR:
  - mem_we=1 for exactly one cycle; mem_addr and mem_wdata stable throughout.
  - Then addr_q+1, cnt_q-1.
  - cnt_q==1 -> DONE, else WR_WAIT.
- DONE: done=1 for one cycle, then IDLE.
- Latency:
  - Load: rd_valid first rises 2 cycles after the request handshake.
  - Throughput: 1 word per 2 cycles with rd_ready held high.
  - Store: mem_we rises 1 cycle after each wr handshake; 1 word per 2 cycles.
- Address arithmetic: addr_q increments modulo 2^DataWidth (0xFF -> 0x00, no error).
- mem_we=0 in every state except WR, and whenever nReset=0, so the memory's reset initialisation is never overwritten.
- Reset mid-burst: at the next rising edge with nReset=0, return to IDLE with reset values. Any in-flight word is dropped and no done pulse is issued.
- A request presented while busy is not accepted; req_valid may stay high.
- rd_ready high while rd_valid=0 is ignored. wr_valid while wr_ready=0 is ignored.

Decomposition:
- Shared package uproc_pkg:
  - lsu_state_t enum: IDLE, RD, RD_OUT, WR_WAIT, WR, DONE.
  - Constants LSU_OP_LOAD=0 and LSU_OP_STORE=1.
  - DATA_WIDTH default 8.
- No sub-module required. Address/count registers stay inline in the FSM.

Test Plan:
- After reset (memory holds DataMem[i]=i): load addr=0x10 len=3, rd_ready=1 -> rd_data 0x10,0x11,0x12; rd_valid first rises 2 cycles after the handshake; done pulses once; mem_we never 1.
- Store addr=0x20 len=2, wr_data 0xA5 then 0x5A, then load 0x20 len=2 -> reads 0xA5, 0x5A; exactly two mem_we pulses, each 1 cycle wide, at mem_addr 0x20 and 0x21.
- Load addr=0xFE len=4 -> mem_addr sequence 0xFE, 0xFF, 0x00, 0x01; data 0xFE, 0xFF, 0x00, 0x01.
- Load len=2, rd_ready low for 5 cycles on the first word -> rd_data stays 0x..., rd_valid held, mem_addr unchanged; burst resumes on rd_ready.
- len=0 request -> done pulses 1 cycle after the handshake; no memory access.
- nReset low mid store burst (after 1 of 3 words) -> next edge: mem_we=0, busy=0, req_ready=1, no done; memory restored to DataMem[i]=i.

Source files
------------

// File: rtl/uproc_pkg.sv
// Shared definitions for the micro-processor datapath blocks.
//   DATA_WIDTH   : default width of data words and memory addresses
//   LSU_OP_*     : encoding of the load/store request direction (req_store)
//   lsu_state_t  : load/store unit sequencer states
package uproc_pkg;

   localparam int unsigned DATA_WIDTH = 8;

   localparam logic LSU_OP_LOAD  = 1'b0;
   localparam logic LSU_OP_STORE = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StRdOut,
      StWrWait,
      StWr,
      StDone
   } lsu_state_t;

endpackage

// File: rtl/data_mem_lsu.sv
// Load/store unit: initiator side of the data memory port.
// Accepts single or burst requests, drives the memory address/write-enable/write-data
// inputs and samples the memory's combinational read data.
//   clk, nReset                      : clock, synchronous active-low reset
//   req_valid/req_ready              : request handshake
//   req_store/req_addr/req_len       : direction, base address, word count (0 = no access)
//   rd_data/rd_valid/rd_ready        : load data stream out
//   wr_data/wr_valid/wr_ready        : store data stream in
//   done                             : one-cycle pulse when a burst finishes
//   busy                             : sequencer not idle
//   mem_addr/mem_we/mem_wdata        : to memory
//   mem_rdata                        : from memory (combinational, 0 while mem_we=1)
module data_mem_lsu
   import uproc_pkg::*;
#(
   parameter int unsigned DataWidth = DATA_WIDTH,
   parameter int unsigned LenWidth  = 8
) (
   input  logic                 clk,
   input  logic                 nReset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_store,
   input  logic [DataWidth-1:0] req_addr,
   input  logic [LenWidth-1:0]  req_len,
   output logic [DataWidth-1:0] rd_data,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   input  logic [DataWidth-1:0] wr_data,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   output logic                 done,
   output logic                 busy,
   output logic [DataWidth-1:0] mem_addr,
   output logic                 mem_we,
   output logic [DataWidth-1:0] mem_wdata,
   input  logic [DataWidth-1:0] mem_rdata
);

   lsu_state_t           state_q, state_d;
   logic [DataWidth-1:0] addr_q, addr_d;
   logic [LenWidth-1:0]  cnt_q, cnt_d;
   logic                 op_q, op_d;
   logic [DataWidth-1:0] mem_addr_q, mem_addr_d;
   logic                 mem_we_q, mem_we_d;
   logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
   logic [DataWidth-1:0] rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 wr_ready_q, wr_ready_d;
   logic                 done_q, done_d;

   logic                 advance;
   logic [DataWidth-1:0] addr_inc;

   // Wraps modulo 2^DataWidth.
   assign addr_inc = addr_q + DataWidth'(1);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = rd_valid_q;
      wr_ready_d  = wr_ready_q;
      done_d      = 1'b0;
      advance     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               addr_d = req_addr;
               cnt_d  = req_len;
               op_d   = req_store;
               if (req_len == '0) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else if (req_store == LSU_OP_STORE) begin
                  state_d    = StWrWait;
                  wr_ready_d = 1'b1;
               end else begin
                  state_d    = StRd;
                  mem_addr_d = req_addr;
               end
            end
         end
         StRd: begin
            // mem_we is always 0 here, so mem_rdata is a genuine read.
            rd_data_d  = mem_rdata;
            rd_valid_d = 1'b1;
            state_d    = StRdOut;
         end
         StRdOut: begin
            if (rd_ready) begin
               rd_valid_d = 1'b0;
               advance    = 1'b1;
            end
         end
         StWrWait: begin
            if (wr_valid) begin
               mem_wdata_d = wr_data;
               mem_addr_d  = addr_q;
               wr_ready_d  = 1'b0;
               mem_we_d    = 1'b1;
               state_d     = StWr;
            end
         end
         StWr: begin
            advance = 1'b1;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Common end-of-word bookkeeping for loads and stores.
      if (advance) begin
         addr_d = addr_inc;
         cnt_d  = cnt_q - LenWidth'(1);
         if (cnt_q == LenWidth'(1)) begin
            state_d = StDone;
            done_d  = 1'b1;
         end else if (op_q == LSU_OP_STORE) begin
            state_d    = StWrWait;
            wr_ready_d = 1'b1;
         end else begin
            state_d    = StRd;
            mem_addr_d = addr_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nReset) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         cnt_q       <= '0;
         op_q        <= LSU_OP_LOAD;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         wr_ready_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         wr_ready_q  <= wr_ready_d;
         done_q      <= done_d;
      end
   end

   // Gate write-enable with reset so a write cycle cut short by reset cannot clobber
   // the memory's own reset initialisation.
   assign mem_we    = mem_we_q & nReset;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign wr_ready  = wr_ready_q;
   assign done      = done_q;
   assign req_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;

   logic       clk = 1'b0;
   logic       nReset;
   logic       req_valid, req_ready, req_store;
   logic [7:0] req_addr, req_len;
   logic [7:0] rd_data;
   logic       rd_valid, rd_ready;
   logic [7:0] wr_data;
   logic       wr_valid, wr_ready;
   logic       done, busy;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_we;

   always #5 clk = ~clk;

   data_mem_lsu #(.DataWidth(8), .LenWidth(8)) dut (
      .clk       (clk),
      .nReset    (nReset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_store (req_store),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .done      (done),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Data memory: reset loads DataMem[i]=i; read is combinational and 0 while writing.
   logic [7:0] dmem [256];
   always @(posedge clk) begin
      if (!nReset) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 8'(i);
      end else if (mem_we) begin
         dmem[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = mem_we ? 8'h00 : dmem[mem_addr];

   // Monitor for done pulses and write-enable activity.
   int         done_cnt = 0, we_cnt = 0, we_wide = 0;
   logic [7:0] we_addr [8];
   logic [7:0] we_data [8];
   logic       we_prev = 1'b0;
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (mem_we) begin
         if (we_cnt < 8) begin
            we_addr[we_cnt] = mem_addr;
            we_data[we_cnt] = mem_wdata;
         end
         we_cnt++;
         if (we_prev) we_wide++;
      end
      we_prev = mem_we;
   end

   int         errors = 0, checks = 0;
   logic [7:0] got_data [8];
   logic [7:0] got_addr [8];
   int         got_n, first_valid;
   logic       timed_out;
   logic [7:0] wdat [4];

   task automatic clear_mon();
      @(posedge clk); #1;
      done_cnt = 0; we_cnt = 0; we_wide = 0;
   endtask

   task automatic start_req(input logic store, input logic [7:0] addr, input logic [7:0] len);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL req_ready_idle: got %0b want 1", req_ready);
      end
      req_valid = 1'b1; req_store = store; req_addr = addr; req_len = len;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Collects load words (rd_ready held high) until done or cycle budget expires.
   task automatic collect_load();
      got_n = 0; first_valid = 0; timed_out = 1'b1;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         if (rd_valid) begin
            if (first_valid == 0) first_valid = c;
            if (got_n < 8) begin
               got_data[got_n] = rd_data;
               got_addr[got_n] = mem_addr;
            end
            got_n++;
         end
         if (done) begin
            timed_out = 1'b0;
            break;
         end
      end
      #1;
   endtask

   task automatic run_load(input logic [7:0] addr, input logic [7:0] len);
      rd_ready = 1'b1;
      clear_mon();
      start_req(1'b0, addr, len);
      collect_load();
   endtask

   task automatic store_words(input int n);
      logic ok;
      for (int w = 0; w < n; w++) begin
         ok = 1'b0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wr_ready) begin
               ok = 1'b1;
               break;
            end
         end
         checks++;
         if (!ok) begin
            errors++; $display("FAIL wr_ready_wait: got 0 want 1 within 20 cycles");
         end
         wr_valid = 1'b1; wr_data = wdat[w];
         @(posedge clk); #1;
         wr_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      nReset = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_addr = 8'h00; req_len = 8'h00;
      rd_ready = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %0b want 0", mem_we); end
      checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mem_addr: got %0h want 00", mem_addr); end
      checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mem_wdata: got %0h want 00", mem_wdata); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data: got %0h want 00", rd_data); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %0b want 0", rd_valid); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready: got %0b want 0", wr_ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
      nReset = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %0b want 1", req_ready); end
   endtask

   task automatic test_load();
      run_load(8'h10, 8'd3);
      checks++; if (timed_out) begin errors++; $display("FAIL load_timeout: got no done want done"); end
      checks++; if (got_n != 3) begin errors++; $display("FAIL load_count: got %0d want 3", got_n); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got_data[i] !== 8'h10 + 8'(i)) begin
            errors++; $display("FAIL load_data[%0d]: got %0h want %0h", i, got_data[i], 8'h10 + 8'(i));
         end
      end
      checks++; if (first_valid != 2) begin errors++; $display("FAIL load_latency: got %0d want 2", first_valid); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL load_done_cnt: got %0d want 1", done_cnt); end
      checks++; if (we_cnt != 0) begin errors++; $display("FAIL load_no_we: got %0d want 0", we_cnt); end
   endtask

   task automatic test_store();
      logic seen;
      clear_mon();
      start_req(1'b1, 8'h20, 8'd2);
      wdat[0] = 8'hA5; wdat[1] = 8'h5A;
      store_words(2);
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      #1;
      checks++; if (!seen) begin errors++; $display("FAIL store_done: got 0 want 1"); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL store_done_cnt: got %0d want 1", done_cnt); end
      checks++; if (we_cnt != 2) begin errors++; $display("FAIL store_we_cnt: got %0d want 2", we_cnt); end
      checks++; if (we_wide != 0) begin errors++; $display("FAIL store_we_width: got %0d want 0", we_wide); end
      checks++; if (we_addr[0] !== 8'h20) begin errors++; $display("FAIL store_addr0: got %0h want 20", we_addr[0]); end
      checks++; if (we_addr[1] !== 8'h21) begin errors++; $display("FAIL store_addr1: got %0h want 21", we_addr[1]); end
      checks++; if (we_data[0] !== 8'hA5) begin errors++; $display("FAIL store_data0: got %0h want a5", we_data[0]); end
      checks++; if (we_data[1] !== 8'h5A) begin errors++; $display("FAIL store_data1: got %0h want 5a", we_data[1]); end
      run_load(8'h20, 8'd2);
      checks++; if (got_n != 2) begin errors++; $display("FAIL readback_count: got %0d want 2", got_n); end
      checks++; if (got_data[0] !== 8'hA5) begin errors++; $display("FAIL readback0: got %0h want a5", got_data[0]); end
      checks++; if (got_data[1] !== 8'h5A) begin errors++; $display("FAIL readback1: got %0h want 5a", got_data[1]); end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_w [4];
      exp_w[0] = 8'hFE; exp_w[1] = 8'hFF; exp_w[2] = 8'h00; exp_w[3] = 8'h01;
      run_load(8'hFE, 8'd4);
      checks++; if (got_n != 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", got_n); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got_addr[i] !== exp_w[i]) begin
            errors++; $display("FAIL wrap_addr[%0d]: got %0h want %0h", i, got_addr[i], exp_w[i]);
         end
         checks++;
         if (got_data[i] !== exp_w[i]) begin
            errors++; $display("FAIL wrap_data[%0d]: got %0h want %0h", i, got_data[i], exp_w[i]);
         end
      end
   endtask

   task automatic test_stall();
      logic seen;
      rd_ready = 1'b0;
      clear_mon();
      start_req(1'b0, 8'h30, 8'd2);
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rd_valid) begin
            seen = 1'b1;
            break;
         end
      end
      checks++; if (!seen) begin errors++; $display("FAIL stall_first_valid: got 0 want 1"); end
      for (int k = 0; k < 5; k++) begin
         checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0b want 1", k, rd_valid); end
         checks++; if (rd_data !== 8'h30) begin errors++; $display("FAIL stall_data[%0d]: got %0h want 30", k, rd_data); end
         checks++; if (mem_addr !== 8'h30) begin errors++; $display("FAIL stall_addr[%0d]: got %0h want 30", k, mem_addr); end
         @(negedge clk);
      end
      rd_ready = 1'b1;
      collect_load();
      checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout: got no done want done"); end
      checks++; if (got_n != 1) begin errors++; $display("FAIL stall_resume_count: got %0d want 1", got_n); end
      checks++; if (got_data[0] !== 8'h31) begin errors++; $display("FAIL stall_resume_data: got %0h want 31", got_data[0]); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done_cnt: got %0d want 1", done_cnt); end
   endtask

   task automatic test_len_zero();
      clear_mon();
      start_req(1'b0, 8'h40, 8'd0);
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL len0_done: got %0b want 1", done); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL len0_busy: got %0b want 1", busy); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL len0_rd_valid: got %0b want 0", rd_valid); end
      @(negedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL len0_done_clear: got %0b want 0", done); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL len0_idle: got %0b want 1", req_ready); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL len0_done_cnt: got %0d want 1", done_cnt); end
      checks++; if (we_cnt != 0) begin errors++; $display("FAIL len0_no_we: got %0d want 0", we_cnt); end
      checks++; if (mem_addr !== 8'h31) begin errors++; $display("FAIL len0_addr_held: got %0h want 31", mem_addr); end
   endtask

   task automatic test_reset_mid_store();
      clear_mon();
      start_req(1'b1, 8'h50, 8'd3);
      wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
      store_words(1);
      @(negedge clk);
      @(negedge clk);
      // Waiting for the second word; a pending write word is presented alongside reset.
      nReset = 1'b0; wr_valid = 1'b1; wr_data = 8'h22;
      @(negedge clk); #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_rst_mem_we: got %0b want 0", mem_we); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b want 0", busy); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_req_ready: got %0b want 1", req_ready); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_wr_ready: got %0b want 0", wr_ready); end
      checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL mid_rst_mem_addr: got %0h want 00", mem_addr); end
      checks++; if (done_cnt != 0) begin errors++; $display("FAIL mid_rst_no_done: got %0d want 0", done_cnt); end
      checks++; if (we_cnt != 1) begin errors++; $display("FAIL mid_rst_we_cnt: got %0d want 1", we_cnt); end
      wr_valid = 1'b0;
      @(negedge clk);
      nReset = 1'b1;
      run_load(8'h50, 8'd1);
      checks++; if (got_data[0] !== 8'h50) begin errors++; $display("FAIL mid_rst_restore50: got %0h want 50", got_data[0]); end
      run_load(8'h20, 8'd1);
      checks++; if (got_data[0] !== 8'h20) begin errors++; $display("FAIL mid_rst_restore20: got %0h want 20", got_data[0]); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_wrap();
      test_stall();
      test_len_zero();
      test_reset_mid_store();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
